// File: rtl/camera_dma_pkg.sv
// Shared definitions for the camera frame DMA: register map, CTRL/STATUS bit
// positions and the write-master state encoding.
package camera_dma_pkg;

    localparam logic [2:0] REG_CTRL        = 3'd0;
    localparam logic [2:0] REG_STATUS      = 3'd1;
    localparam logic [2:0] REG_BUF0        = 3'd2;
    localparam logic [2:0] REG_BUF1        = 3'd3;
    localparam logic [2:0] REG_FRAME_WORDS = 3'd4;
    localparam logic [2:0] REG_LAST_BUF    = 3'd5;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        WAIT_DATA,
        BURST,
        DONE
    } dma_state_t;

endpackage

// File: rtl/camera_dma_regs.sv
// HPS-facing register file for the camera DMA: slave decode, sticky W1C status
// bits, registered readback and the frame-done interrupt.
module camera_dma_regs
    import camera_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        s_address,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    input  logic              s_read,
    output logic [31:0]       s_readdata,
    input  logic              busy,
    input  logic              set_done,
    input  logic              set_overflow,
    input  logic              clear_run,
    input  logic              last_buf_we,
    input  logic              last_buf_d,
    output logic              run,
    output logic              continuous,
    output logic              irq_en,
    output logic [ADDR_W-1:0] buf0_base,
    output logic [ADDR_W-1:0] buf1_base,
    output logic [CNT_W-1:0]  frame_words,
    output logic              irq
);

    logic done;
    logic overflow;
    logic last_buf;

    logic wr_ctrl;
    logic wr_status;
    logic wr_buf0;
    logic wr_buf1;
    logic wr_frame_words;

    assign wr_ctrl        = s_write && (s_address == REG_CTRL);
    assign wr_status      = s_write && (s_address == REG_STATUS);
    assign wr_buf0        = s_write && (s_address == REG_BUF0);
    assign wr_buf1        = s_write && (s_address == REG_BUF1);
    assign wr_frame_words = s_write && (s_address == REG_FRAME_WORDS);

    // A CTRL write landing in the same cycle as the FSM's auto-clear of run is the newer command and wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run        <= 1'b0;
            continuous <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (clear_run) begin
                run <= 1'b0;
            end
            if (wr_ctrl) begin
                run        <= s_writedata[CTRL_RUN];
                continuous <= s_writedata[CTRL_CONT];
                irq_en     <= s_writedata[CTRL_IRQ_EN];
            end
        end
    end

    // Sticky status: a hardware set in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done     <= set_done     | (done     & ~(wr_status & s_writedata[STAT_DONE]));
            overflow <= set_overflow | (overflow & ~(wr_status & s_writedata[STAT_OVF]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0_base   <= '0;
            buf1_base   <= '0;
            frame_words <= '0;
            last_buf    <= 1'b0;
        end else begin
            if (wr_buf0) begin
                buf0_base <= ADDR_W'(s_writedata);
            end
            if (wr_buf1) begin
                buf1_base <= ADDR_W'(s_writedata);
            end
            if (wr_frame_words) begin
                frame_words <= CNT_W'(s_writedata);
            end
            if (last_buf_we) begin
                last_buf <= last_buf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdata <= '0;
        end else if (s_read) begin
            case (s_address)
                REG_CTRL:        s_readdata <= {29'd0, irq_en, continuous, run};
                REG_STATUS:      s_readdata <= {29'd0, overflow, done, busy};
                REG_BUF0:        s_readdata <= 32'(buf0_base);
                REG_BUF1:        s_readdata <= 32'(buf1_base);
                REG_FRAME_WORDS: s_readdata <= 32'(frame_words);
                REG_LAST_BUF:    s_readdata <= {31'd0, last_buf};
                default:         s_readdata <= '0;
            endcase
        end
    end

    assign irq = done & irq_en;

endmodule

// File: rtl/camera_frame_dma.sv
// Avalon-MM burst write master that drains the camera pixel FIFO into
// double-buffered DDR frame buffers and reports completion to the HPS.
module camera_frame_dma
    import camera_dma_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 24,
    parameter int USEDW_W   = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         s_address,
    input  logic               s_write,
    input  logic [31:0]        s_writedata,
    input  logic               s_read,
    output logic [31:0]        s_readdata,
    output logic [ADDR_W-1:0]  m_address,
    output logic               m_write,
    output logic [31:0]        m_writedata,
    output logic [6:0]         m_burstcount,
    input  logic               m_waitrequest,
    input  logic [31:0]        fifo_rdata,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    input  logic               frame_start,
    output logic               irq
);

    dma_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  remaining_next;
    logic [6:0]        beat_cnt;
    logic [6:0]        next_len;
    logic              active;

    logic              run;
    logic              continuous;
    logic              irq_en;
    logic [ADDR_W-1:0] buf0_base;
    logic [ADDR_W-1:0] buf1_base;
    logic [CNT_W-1:0]  frame_words;

    logic              accept;
    logic              last_beat;
    logic              busy;
    logic              set_done;
    logic              set_overflow;
    logic              clear_run;

    camera_dma_regs #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_read       (s_read),
        .s_readdata   (s_readdata),
        .busy         (busy),
        .set_done     (set_done),
        .set_overflow (set_overflow),
        .clear_run    (clear_run),
        .last_buf_we  (set_done),
        .last_buf_d   (active),
        .run          (run),
        .continuous   (continuous),
        .irq_en       (irq_en),
        .buf0_base    (buf0_base),
        .buf1_base    (buf1_base),
        .frame_words  (frame_words),
        .irq          (irq)
    );

    assign m_address   = addr;
    assign m_writedata = fifo_rdata;
    assign accept      = m_write & ~m_waitrequest;
    assign fifo_rdreq  = accept;
    assign last_beat   = accept && (beat_cnt == (m_burstcount - 7'd1));

    assign busy         = (state != IDLE);
    assign set_done     = (state == DONE);
    assign clear_run    = (state == DONE) && !(run && continuous);
    assign set_overflow = frame_start && ((state == WAIT_DATA) || (state == BURST));

    assign remaining_next = remaining - CNT_W'(m_burstcount);

    // Length of the next burst: a full burst, or whatever is left of the frame.
    always_comb begin
        next_len = 7'(BURST_LEN);
        if (remaining < CNT_W'(BURST_LEN)) begin
            next_len = 7'(remaining);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            beat_cnt     <= '0;
            m_burstcount <= '0;
            m_write      <= 1'b0;
            active       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (frame_start) begin
                        if (frame_words == '0) begin
                            state <= DONE;
                        end else begin
                            addr      <= active ? buf1_base : buf0_base;
                            remaining <= frame_words;
                            state     <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (32'(fifo_usedw) >= 32'(next_len)) begin
                        m_burstcount <= next_len;
                        m_write      <= 1'b1;
                        beat_cnt     <= '0;
                        state        <= BURST;
                    end
                end
                BURST: begin
                    // Address and burstcount stay frozen until the final beat is accepted.
                    if (last_beat) begin
                        m_write   <= 1'b0;
                        beat_cnt  <= '0;
                        addr      <= addr + ADDR_W'({m_burstcount, 2'b00});
                        remaining <= remaining_next;
                        if (!run) begin
                            state <= IDLE;
                        end else if (remaining_next == '0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                DONE: begin
                    active <= ~active;
                    if (run && continuous) begin
                        state <= WAIT_SOF;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_dma.sv
// Scoreboard bench for camera_frame_dma: directed frames with a FIFO/slave model,
// expected bursts, beats, register reads and irq levels checked by a monitor.
module tb_camera_frame_dma;
    import camera_dma_pkg::*;

    localparam int BURST_LEN = 16;
    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 24;
    localparam int USEDW_W   = 9;

    typedef struct {
        logic [31:0] addr;
        logic [6:0]  cnt;
    } burst_t;

    typedef struct {
        int          a;
        logic [31:0] v;
    } rd_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [2:0]         s_address = '0;
    logic               s_write = 1'b0;
    logic [31:0]        s_writedata = '0;
    logic               s_read = 1'b0;
    logic [31:0]        s_readdata;
    logic [ADDR_W-1:0]  m_address;
    logic               m_write;
    logic [31:0]        m_writedata;
    logic [6:0]         m_burstcount;
    logic               m_waitrequest = 1'b0;
    logic [31:0]        fifo_rdata = '0;
    logic [USEDW_W-1:0] fifo_usedw = '0;
    logic               fifo_rdreq;
    logic               frame_start = 1'b0;
    logic               irq;

    burst_t      exp_bursts[$];
    logic [31:0] exp_data[$];
    rd_t         rd_q[$];
    logic        irq_q[$];
    logic [31:0] fifo_q[$];

    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          wr_cycles = 0;
    int          beat_idx = 0;
    int          usedw_override = -1;
    logic [31:0] cur_addr = '0;
    logic [6:0]  cur_cnt = '0;
    bit          rand_wait = 1'b0;
    bit          pending_pop = 1'b0;
    bit          rd_seen = 1'b0;

    camera_frame_dma #(
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .USEDW_W   (USEDW_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_burstcount  (m_burstcount),
        .m_waitrequest (m_waitrequest),
        .fifo_rdata    (fifo_rdata),
        .fifo_usedw    (fifo_usedw),
        .fifo_rdreq    (fifo_rdreq),
        .frame_start   (frame_start),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noteFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    always @(posedge clk) rd_seen <= s_read;

    // FIFO/slave model plus monitor; inputs change only on the falling edge.
    always @(negedge clk) begin
        int u;
        if (pending_pop) begin
            if (fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
            end else begin
                noteFail("fifo_underflow");
            end
            pending_pop = 1'b0;
        end
        m_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        u = (usedw_override >= 0) ? usedw_override : fifo_q.size();
        if (u > 511) u = 511;
        fifo_usedw = USEDW_W'(u);
        #1;
        if (!reset_n) begin
            beat_idx = 0;
        end else begin
            if (m_write) wr_cycles++;
            if (m_write && !m_waitrequest) begin
                if (beat_idx == 0) begin
                    if (exp_bursts.size() > 0) begin
                        burst_t b;
                        b = exp_bursts.pop_front();
                        checkOutput("burst_addr", m_address, b.addr);
                        checkOutput("burst_len", 32'(m_burstcount), 32'(b.cnt));
                        cur_addr = b.addr;
                        cur_cnt  = b.cnt;
                    end else begin
                        noteFail("unexpected_burst");
                        cur_addr = m_address;
                        cur_cnt  = m_burstcount;
                    end
                end else begin
                    checkOutput("addr_hold", m_address, cur_addr);
                    checkOutput("len_hold", 32'(m_burstcount), 32'(cur_cnt));
                end
                if (exp_data.size() > 0) begin
                    checkOutput("beat_data", m_writedata, exp_data.pop_front());
                end else begin
                    noteFail("unexpected_beat");
                end
                beat_idx++;
                if (beat_idx >= int'(cur_cnt)) beat_idx = 0;
                pending_pop = 1'b1;
                beats++;
            end
            if (rd_seen) begin
                if (rd_q.size() > 0) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    checkOutput($sformatf("reg%0d_read", r.a), s_readdata, r.v);
                end else begin
                    noteFail("unexpected_read");
                end
            end
            if (irq_q.size() > 0) begin
                checkOutput("irq", {31'd0, irq}, {31'd0, irq_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeRegNow(input logic [2:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        @(negedge clk);
        s_write     = 1'b0;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        writeRegNow(a, d);
    endtask

    task automatic readRegNow(input logic [2:0] a, input logic [31:0] exp);
        rd_t r;
        r.a = int'(a);
        r.v = exp;
        rd_q.push_back(r);
        s_address = a;
        s_read    = 1'b1;
        @(negedge clk);
        s_read    = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        readRegNow(a, exp);
    endtask

    task automatic expectIrq(input logic v);
        irq_q.push_back(v);
        tick(1);
    endtask

    task automatic pulseSof();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic flushAll();
        fifo_q.delete();
        exp_data.delete();
        exp_bursts.delete();
        pending_pop = 1'b0;
    endtask

    // Loads the FIFO and predicts bursts for the first exp_words words of a frame at base.
    task automatic applyStimulus(input logic [31:0] base, input int exp_words,
                                 input int fifo_words, input logic [15:0] seed, input bit pulse);
        int rem;
        int n;
        logic [31:0] a;
        logic [31:0] w;
        for (int i = 0; i < fifo_words; i++) begin
            w = {seed, 16'(i)};
            fifo_q.push_back(w);
            if (i < exp_words) exp_data.push_back(w);
        end
        rem = exp_words;
        a = base;
        while (rem > 0) begin
            burst_t b;
            n = (rem < BURST_LEN) ? rem : BURST_LEN;
            b.addr = a;
            b.cnt  = 7'(n);
            exp_bursts.push_back(b);
            a = a + 32'(4 * n);
            rem = rem - n;
        end
        if (pulse) pulseSof();
    endtask

    task automatic waitDrain(input int budget);
        int k;
        k = 0;
        while ((exp_data.size() > 0 || exp_bursts.size() > 0 || beat_idx != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_data.size() > 0 || exp_bursts.size() > 0) noteFail("drain_timeout");
        tick(4);
    endtask

    task automatic waitBeats(input int base_count, input int n, input int budget);
        int k;
        k = 0;
        while (beats - base_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (beats - base_count < n) noteFail("beat_wait_timeout");
    endtask

    initial begin
        #500000;
        noteFail("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int b0;
        // Reset values while reset is held
        #3;
        checkOutput("rst_m_write", {31'd0, m_write}, 32'd0);
        checkOutput("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_readdata", s_readdata, 32'd0);
        tick(2);
        reset_n = 1'b1;
        readReg(REG_CTRL, 32'd0);
        readReg(REG_STATUS, 32'd0);
        readReg(REG_FRAME_WORDS, 32'd0);
        readReg(REG_LAST_BUF, 32'd0);

        $display("[TB] single frame, 40 words into BUF0");
        writeReg(REG_BUF0, 32'h1000_0000);
        writeReg(REG_FRAME_WORDS, 32'd40);
        writeReg(REG_CTRL, 32'h5);
        tick(2);
        applyStimulus(32'h1000_0000, 40, 64, 16'hA001, 1'b1);
        waitDrain(500);
        readReg(REG_STATUS, 32'h2);
        readReg(REG_LAST_BUF, 32'd0);
        readReg(REG_CTRL, 32'h4);
        expectIrq(1'b1);
        checkOutput("pops_t1", 32'(fifo_q.size()), 32'd24);
        writeReg(REG_STATUS, 32'h2);
        expectIrq(1'b0);

        $display("[TB] random waitrequest, frame into BUF1");
        flushAll();
        rand_wait = 1'b1;
        writeReg(REG_BUF1, 32'h3000_0000);
        writeReg(REG_CTRL, 32'h5);
        tick(2);
        applyStimulus(32'h3000_0000, 40, 40, 16'hB002, 1'b1);
        waitDrain(1500);
        rand_wait = 1'b0;
        readReg(REG_STATUS, 32'h2);
        readReg(REG_LAST_BUF, 32'd1);
        expectIrq(1'b1);
        checkOutput("pops_t2", 32'(fifo_q.size()), 32'd0);
        writeReg(REG_STATUS, 32'h2);

        $display("[TB] continuous mode ping-pong");
        flushAll();
        writeReg(REG_BUF1, 32'h2000_0000);
        writeReg(REG_FRAME_WORDS, 32'd20);
        writeReg(REG_CTRL, 32'h3);
        tick(2);
        applyStimulus(32'h1000_0000, 20, 20, 16'hC001, 1'b1);
        waitDrain(500);
        readReg(REG_LAST_BUF, 32'd0);
        readReg(REG_STATUS, 32'h3);
        applyStimulus(32'h2000_0000, 20, 20, 16'hC002, 1'b1);
        waitDrain(500);
        readReg(REG_LAST_BUF, 32'd1);
        applyStimulus(32'h1000_0000, 20, 20, 16'hC003, 1'b1);
        waitDrain(500);
        readReg(REG_LAST_BUF, 32'd0);
        expectIrq(1'b0);
        writeReg(REG_CTRL, 32'h0);
        tick(2);
        readReg(REG_STATUS, 32'h2);
        writeReg(REG_STATUS, 32'h2);
        readReg(REG_STATUS, 32'h0);

        $display("[TB] starved FIFO and overflow");
        flushAll();
        usedw_override = 10;
        writeReg(REG_FRAME_WORDS, 32'd32);
        writeReg(REG_CTRL, 32'h1);
        tick(2);
        wr_cycles = 0;
        applyStimulus(32'h2000_0000, 32, 40, 16'hD004, 1'b1);
        tick(20);
        checkOutput("no_write_usedw10", 32'(wr_cycles), 32'd0);
        pulseSof();
        readReg(REG_STATUS, 32'h5);
        writeReg(REG_STATUS, 32'h4);
        readReg(REG_STATUS, 32'h1);
        usedw_override = 15;
        tick(6);
        checkOutput("no_write_usedw15", 32'(wr_cycles), 32'd0);
        usedw_override = 16;
        waitDrain(500);
        usedw_override = -1;
        readReg(REG_STATUS, 32'h2);
        readReg(REG_LAST_BUF, 32'd1);
        checkOutput("pops_t4", 32'(fifo_q.size()), 32'd8);
        writeReg(REG_STATUS, 32'h2);

        $display("[TB] run cleared mid-burst");
        flushAll();
        writeReg(REG_CTRL, 32'h1);
        tick(2);
        b0 = beats;
        applyStimulus(32'h1000_0000, 16, 40, 16'hE005, 1'b1);
        waitBeats(b0, 5, 200);
        writeRegNow(REG_CTRL, 32'h0);
        waitDrain(300);
        tick(10);
        readReg(REG_STATUS, 32'h0);
        readReg(REG_CTRL, 32'h0);
        checkOutput("pops_t5", 32'(fifo_q.size()), 32'd24);

        $display("[TB] empty frame, then reset mid-burst");
        flushAll();
        writeReg(REG_FRAME_WORDS, 32'd0);
        writeReg(REG_CTRL, 32'h5);
        tick(2);
        wr_cycles = 0;
        pulseSof();
        tick(1);
        readRegNow(REG_STATUS, 32'h2);
        checkOutput("zero_frame_writes", 32'(wr_cycles), 32'd0);
        readReg(REG_LAST_BUF, 32'd0);
        expectIrq(1'b1);
        writeReg(REG_FRAME_WORDS, 32'd40);
        writeReg(REG_CTRL, 32'h5);
        tick(2);
        readReg(REG_STATUS, 32'h3);
        b0 = beats;
        applyStimulus(32'h2000_0000, 40, 48, 16'hF006, 1'b1);
        waitBeats(b0, 3, 200);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_m_write", {31'd0, m_write}, 32'd0);
        checkOutput("arst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        checkOutput("arst_irq", {31'd0, irq}, 32'd0);
        checkOutput("arst_readdata", s_readdata, 32'd0);
        flushAll();
        tick(2);
        flushAll();
        reset_n = 1'b1;
        readReg(REG_CTRL, 32'h0);
        readReg(REG_STATUS, 32'h0);
        readReg(REG_BUF1, 32'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
